// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode classification
// helpers for the nibble-serial ALU sequencer.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_ADD = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Shifts and SLT do not decompose into independent nibbles, so they are rejected.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
               (op == OP_SUB) || (op == OP_ADD);
    endfunction

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Runs W-bit ADD/SUB/AND/OR/XOR on an external 4-bit ALU, one nibble per cycle,
// LSB nibble first, chaining carry/borrow and collecting the result and N/Z/C/V.
module alu_nibble_sequencer
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   ready,
    output logic                   done,
    output logic                   err,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   n,
    output logic                   z,
    output logic                   c,
    output logic                   v,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_op,
    output logic                   alu_cin,
    input  logic [3:0]             alu_y,
    input  logic                   alu_c,
    input  logic                   alu_v
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    state_t          r_state;
    state_t          w_nextState;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;
    logic            r_cin;
    logic            r_carry;
    logic [W-1:0]    r_result;
    logic            r_err;
    logic            r_n;
    logic            r_z;
    logic            r_c;
    logic            r_v;

    logic            w_lastNibble;
    logic            w_isArith;
    logic [W-1:0]    w_aShift;
    logic [W-1:0]    w_bShift;
    logic [W-1:0]    w_ySpread;
    logic [W-1:0]    w_newResult;

    assign w_lastNibble = (r_idx == IW'(NIBBLES - 1));
    assign w_isArith    = is_arith_op(r_op);
    assign w_aShift     = r_a >> {r_idx, 2'b00};
    assign w_bShift     = r_b >> {r_idx, 2'b00};
    // The result register is cleared on accept, so OR-ing in each nibble is enough.
    assign w_ySpread    = W'(alu_y) << {r_idx, 2'b00};
    assign w_newResult  = r_result | w_ySpread;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (start) w_nextState = is_legal_op(op) ? S_RUN : S_DONE;
            S_RUN:  if (w_lastNibble) w_nextState = S_DONE;
            S_DONE: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a   = 4'd0;
        alu_b   = 4'd0;
        alu_op  = OP_AND;
        alu_cin = 1'b0;
        if (r_state == S_RUN) begin
            alu_a   = w_aShift[3:0];
            alu_b   = w_bShift[3:0];
            alu_op  = r_op;
            alu_cin = (r_idx == '0) ? r_cin : r_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_AND;
            r_cin    <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_result <= '0;
                        r_n      <= 1'b0;
                        r_z      <= 1'b0;
                        r_c      <= 1'b0;
                        r_v      <= 1'b0;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        if (is_legal_op(op)) begin
                            r_a   <= a;
                            r_b   <= b;
                            r_op  <= op;
                            r_cin <= cin & is_arith_op(op);
                            r_err <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_result <= w_newResult;
                    r_carry  <= alu_c & w_isArith;
                    r_idx    <= r_idx + IW'(1);
                    if (w_lastNibble) begin
                        r_idx <= '0;
                        r_n   <= w_newResult[W-1];
                        r_z   <= (w_newResult == '0);
                        r_c   <= alu_c & w_isArith;
                        r_v   <= alu_v & w_isArith;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign done   = (r_state == S_DONE);
    assign err    = r_err;
    assign result = r_result;
    assign n      = r_n;
    assign z      = r_z;
    assign c      = r_c;
    assign v      = r_v;

endmodule
